// File: rtl/fsm_cpu_ctrl_if.sv
// Signal bundle between the state-overlay side and the PicoRV32 control side.
// master: the controller (fsm_cpu_ctrl). slave: the overlay/CPU environment.
interface fsm_cpu_ctrl_if;
  logic [3:0]  fsm_state;
  logic [15:0] run_mask;
  logic        cpu_resetn;
  logic        cpu_clk_en;
  logic [31:0] cpu_irq;
  logic [31:0] cpu_eoi;
  logic [3:0]  state_code;
  logic        irq_overflow;
  logic        irq_timeout;
  logic        flags_clr;

  modport master (
    input  fsm_state,
    input  run_mask,
    input  cpu_eoi,
    input  flags_clr,
    output cpu_resetn,
    output cpu_clk_en,
    output cpu_irq,
    output state_code,
    output irq_overflow,
    output irq_timeout
  );

  modport slave (
    output fsm_state,
    output run_mask,
    output cpu_eoi,
    output flags_clr,
    input  cpu_resetn,
    input  cpu_clk_en,
    input  cpu_irq,
    input  state_code,
    input  irq_overflow,
    input  irq_timeout
  );
endinterface

// File: rtl/fsm_cpu_ctrl.sv
// PicoRV32 controller driven by fsm_overlay state changes: reset sequencing,
// per-state clock-enable gating, and an interrupt/EOI handshake carrying the
// latched state code, with a one-deep pending slot and sticky status flags.
module fsm_cpu_ctrl #(
  parameter int unsigned RST_HOLD   = 16,
  parameter int unsigned IRQ_NUM    = 3,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [3:0]  RESET_CODE = 4'hF
) (
  input  logic             clk,
  input  logic             rst_n,
  fsm_cpu_ctrl_if.master   bus
);

  // One counter serves both the BOOT hold and the IRQ_WAIT timeout.
  localparam int unsigned CntMax = (RST_HOLD > TIMEOUT) ? RST_HOLD : TIMEOUT;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StBoot, StIdle, StIrqWait} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      prev_q;
  logic [3:0]      code_q, code_d;
  logic [3:0]      pend_q, pend_d;
  logic            pend_vld_q, pend_vld_d;
  logic            resetn_q, resetn_d;
  logic            clk_en_q, clk_en_d;
  logic            irq_q, irq_d;
  logic            ovf_q, ovf_d;
  logic            tmo_q, tmo_d;

  logic            change;
  logic            to_reset;
  logic            eoi_hit;

  assign change   = (bus.fsm_state != prev_q);
  assign to_reset = change && (bus.fsm_state == RESET_CODE);
  assign eoi_hit  = bus.cpu_eoi[IRQ_NUM];

  // Next-state and registered-output logic for the controller.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    resetn_d   = resetn_q;
    clk_en_d   = clk_en_q;
    irq_d      = irq_q;
    // Clear first so a same-cycle set below takes priority.
    ovf_d      = bus.flags_clr ? 1'b0 : ovf_q;
    tmo_d      = bus.flags_clr ? 1'b0 : tmo_q;

    unique case (state_q)
      StBoot: begin
        resetn_d = 1'b0;
        clk_en_d = 1'b0;
        irq_d    = 1'b0;
        if (cnt_q == CntW'(RST_HOLD - 1)) begin
          cnt_d    = '0;
          code_d   = bus.fsm_state;
          resetn_d = 1'b1;
          clk_en_d = bus.run_mask[bus.fsm_state];
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StIdle: begin
        if (to_reset) begin
          state_d    = StBoot;
          cnt_d      = '0;
          resetn_d   = 1'b0;
          irq_d      = 1'b0;
          clk_en_d   = 1'b0;
          pend_vld_d = 1'b0;
        end else if (change || pend_vld_q) begin
          // A live change is newer than anything buffered, so it wins.
          code_d     = change ? bus.fsm_state : pend_q;
          clk_en_d   = bus.run_mask[change ? bus.fsm_state : pend_q];
          irq_d      = 1'b1;
          cnt_d      = '0;
          pend_vld_d = 1'b0;
          state_d    = StIrqWait;
        end
      end

      StIrqWait: begin
        if (to_reset) begin
          state_d    = StBoot;
          cnt_d      = '0;
          resetn_d   = 1'b0;
          irq_d      = 1'b0;
          clk_en_d   = 1'b0;
          pend_vld_d = 1'b0;
        end else begin
          if (change) begin
            pend_d     = bus.fsm_state;
            pend_vld_d = 1'b1;
            if (pend_vld_q) begin
              ovf_d = 1'b1;
            end
          end
          if (eoi_hit) begin
            irq_d   = 1'b0;
            state_d = StIdle;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            irq_d   = 1'b0;
            tmo_d   = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      default: begin
        state_d = StBoot;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      cnt_q      <= '0;
      prev_q     <= '0;
      code_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      resetn_q   <= 1'b0;
      clk_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_q     <= bus.fsm_state;
      code_q     <= code_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      resetn_q   <= resetn_d;
      clk_en_q   <= clk_en_d;
      irq_q      <= irq_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
    end
  end

  // Only the selected interrupt line is ever driven.
  always_comb begin
    bus.cpu_irq          = '0;
    bus.cpu_irq[IRQ_NUM] = irq_q;
  end

  assign bus.cpu_resetn   = resetn_q;
  assign bus.cpu_clk_en   = clk_en_q;
  assign bus.state_code   = code_q;
  assign bus.irq_overflow = ovf_q;
  assign bus.irq_timeout  = tmo_q;

endmodule

// File: tb/tb_fsm_cpu_ctrl.sv
// Bench for fsm_cpu_ctrl: directed scenarios followed by random traffic, all
// checked every cycle against a behavioural model of the controller.
module tb_fsm_cpu_ctrl;
  localparam int unsigned RstHold = 16;
  localparam int unsigned IrqNum  = 3;
  localparam int unsigned Timeout = 255;
  localparam logic [31:0] IrqBit  = 32'h8;

  localparam int MBoot = 0;
  localparam int MIdle = 1;
  localparam int MWait = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fsm_cpu_ctrl_if bus ();

  fsm_cpu_ctrl #(
    .RST_HOLD  (RstHold),
    .IRQ_NUM   (IrqNum),
    .TIMEOUT   (Timeout),
    .RESET_CODE(4'hF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int         m_mode;
  int         m_boot_left;
  int         m_wait;
  logic [3:0] m_prev;
  logic [3:0] m_pend[$];
  logic       m_resetn, m_clk_en, m_irq, m_ovf, m_tmo;
  logic [3:0] m_code;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode      = MBoot;
    m_boot_left = RstHold;
    m_wait      = 0;
    m_prev      = 4'h0;
    m_pend.delete();
    m_resetn    = 1'b0;
    m_clk_en    = 1'b0;
    m_irq       = 1'b0;
    m_ovf       = 1'b0;
    m_tmo       = 1'b0;
    m_code      = 4'h0;
  endtask

  task automatic model_boot();
    m_mode      = MBoot;
    m_boot_left = RstHold;
    m_resetn    = 1'b0;
    m_irq       = 1'b0;
    m_clk_en    = 1'b0;
    m_pend.delete();
  endtask

  task automatic model_raise(input logic [3:0] v);
    m_code   = v;
    m_irq    = 1'b1;
    m_clk_en = bus.run_mask[v];
    m_mode   = MWait;
    m_wait   = 0;
  endtask

  // One rising edge of the controller, from the inputs currently applied.
  task automatic model_edge();
    logic [3:0] fs;
    logic       chg;
    logic       eoi;
    fs  = bus.fsm_state;
    chg = (fs != m_prev);
    eoi = bus.cpu_eoi[IrqNum];
    m_prev = fs;
    if (bus.flags_clr) begin
      m_ovf = 1'b0;
      m_tmo = 1'b0;
    end
    case (m_mode)
      MBoot: begin
        m_boot_left--;
        if (m_boot_left == 0) begin
          m_code   = fs;
          m_resetn = 1'b1;
          m_clk_en = bus.run_mask[fs];
          m_mode   = MIdle;
        end
      end
      MIdle: begin
        if (chg && fs == 4'hF) model_boot();
        else if (chg) begin
          m_pend.delete();
          model_raise(fs);
        end else if (m_pend.size() > 0) model_raise(m_pend.pop_front());
      end
      default: begin
        if (chg && fs == 4'hF) model_boot();
        else begin
          if (chg) begin
            if (m_pend.size() > 0) begin
              m_ovf = 1'b1;
              m_pend.delete();
            end
            m_pend.push_back(fs);
          end
          m_wait++;
          if (eoi) begin
            m_irq  = 1'b0;
            m_mode = MIdle;
          end else if (m_wait == Timeout) begin
            m_irq  = 1'b0;
            m_tmo  = 1'b1;
            m_mode = MIdle;
          end
        end
      end
    endcase
  endtask

  task automatic check_model();
    check_eq("resetn", 32'(bus.cpu_resetn), 32'(m_resetn));
    check_eq("clk_en", 32'(bus.cpu_clk_en), 32'(m_clk_en));
    check_eq("irq", bus.cpu_irq, m_irq ? IrqBit : 32'h0);
    check_eq("state_code", 32'(bus.state_code), 32'(m_code));
    check_eq("overflow", 32'(bus.irq_overflow), 32'(m_ovf));
    check_eq("timeout", 32'(bus.irq_timeout), 32'(m_tmo));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_resetn"}, 32'(bus.cpu_resetn), 32'h0);
    check_eq({tag, "_clk_en"}, 32'(bus.cpu_clk_en), 32'h0);
    check_eq({tag, "_irq"}, bus.cpu_irq, 32'h0);
    check_eq({tag, "_code"}, 32'(bus.state_code), 32'h0);
    check_eq({tag, "_ovf"}, 32'(bus.irq_overflow), 32'h0);
    check_eq({tag, "_tmo"}, 32'(bus.irq_timeout), 32'h0);
  endtask

  initial begin
    bus.fsm_state = 4'd2;
    bus.run_mask  = 16'h0004;
    bus.cpu_eoi   = 32'h0;
    bus.flags_clr = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset hold then first state, no interrupt
    for (int i = 0; i < 15; i++) begin
      step();
      check_eq("boot_hold", 32'(bus.cpu_resetn), 32'h0);
    end
    step();
    check_eq("boot_exit_resetn", 32'(bus.cpu_resetn), 32'h1);
    check_eq("boot_exit_code", 32'(bus.state_code), 32'h2);
    check_eq("boot_exit_clk_en", 32'(bus.cpu_clk_en), 32'h1);
    check_eq("boot_exit_irq", bus.cpu_irq, 32'h0);

    // Single event and EOI
    bus.fsm_state = 4'd5;
    step();
    check_eq("single_irq", bus.cpu_irq, 32'h8);
    check_eq("single_code", 32'(bus.state_code), 32'h5);
    check_eq("single_clk_en", 32'(bus.cpu_clk_en), 32'h0);
    bus.cpu_eoi = 32'h8;
    step();
    check_eq("eoi_irq_low", bus.cpu_irq, 32'h0);
    bus.cpu_eoi = 32'h0;
    step();
    check_eq("eoi_irq_stays_low", bus.cpu_irq, 32'h0);

    // Pending slot and overflow
    bus.fsm_state = 4'd4;
    step();
    bus.fsm_state = 4'd5;
    step();
    bus.fsm_state = 4'd6;
    step();
    bus.fsm_state = 4'd7;
    step();
    check_eq("ovf_set", 32'(bus.irq_overflow), 32'h1);
    bus.cpu_eoi = 32'h8;
    step();
    check_eq("pend_low_cycle", bus.cpu_irq, 32'h0);
    bus.cpu_eoi = 32'h0;
    step();
    check_eq("pend_reraise", bus.cpu_irq, 32'h8);
    check_eq("pend_code", 32'(bus.state_code), 32'h7);
    bus.cpu_eoi = 32'h8;
    step();
    bus.cpu_eoi   = 32'h0;
    bus.flags_clr = 1'b1;
    step();
    check_eq("ovf_clr", 32'(bus.irq_overflow), 32'h0);
    bus.flags_clr = 1'b0;

    // EOI timeout
    bus.fsm_state = 4'd8;
    step();
    for (int i = 0; i < 254; i++) step();
    check_eq("tmo_still_high", bus.cpu_irq, 32'h8);
    step();
    check_eq("tmo_irq_low", bus.cpu_irq, 32'h0);
    check_eq("tmo_flag", 32'(bus.irq_timeout), 32'h1);
    bus.flags_clr = 1'b1;
    step();
    check_eq("tmo_clr", 32'(bus.irq_timeout), 32'h0);
    bus.flags_clr = 1'b0;

    // RESET_CODE while an interrupt is outstanding
    bus.fsm_state = 4'd9;
    step();
    bus.fsm_state = 4'd10;
    step();
    bus.fsm_state = 4'hF;
    step();
    check_eq("rc_resetn", 32'(bus.cpu_resetn), 32'h0);
    check_eq("rc_irq", bus.cpu_irq, 32'h0);
    for (int i = 0; i < 15; i++) step();
    check_eq("rc_hold", 32'(bus.cpu_resetn), 32'h0);
    step();
    check_eq("rc_exit_resetn", 32'(bus.cpu_resetn), 32'h1);
    check_eq("rc_exit_code", 32'(bus.state_code), 32'hF);
    check_eq("rc_exit_irq", bus.cpu_irq, 32'h0);
    step();
    check_eq("rc_no_stale_pend", bus.cpu_irq, 32'h0);

    // Asynchronous reset between edges
    bus.fsm_state = 4'd3;
    step();
    check_eq("ar_irq_before", bus.cpu_irq, 32'h8);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < RstHold; i++) step();
    check_eq("ar_exit_code", 32'(bus.state_code), 32'h3);

    // Random traffic; EOI rate alternates so both EOI and timeout paths occur
    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 1000; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 199) == 0) bus.fsm_state = 4'hF;
          else bus.fsm_state = 4'($urandom_range(0, 14));
        end
        if ($urandom_range(0, 63) == 0) bus.run_mask = 16'($urandom);
        bus.cpu_eoi = $urandom & ~IrqBit;
        if ($urandom_range(0, (blk % 2 == 0) ? 19 : 399) == 0) bus.cpu_eoi = bus.cpu_eoi | IrqBit;
        bus.flags_clr = ($urandom_range(0, 49) == 0);
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
